lcd_pix_packer: RTL and testbench
=================================

# lcd_pix_packer

Downstream of the LCD drive interface. Consumes its two-pixel-per-beat RGB stream (`out_valid`, `out_r0..out_b1` after brightness adjustment) and packs the 48-bit beats into a dense little-endian stream of 32-bit words. Words are buffered in a first-word-fall-through FIFO and presented on a valid/ready port for a capture DMA or frame writer. Tracks frame boundaries by beat count, flushes a trailing partial word, and flags overflow.

## Interface
- `IMG_PIX_W`, 8: bits per colour channel; only 8 is supported.
- `FIFO_DEPTH`, 16: FIFO entries of 32 bits; must be a power of two and at least 4.
- `W_FIFO`, 4: log2(`FIFO_DEPTH`).
- `FRAME_BEATS`, 196608: input beats per frame (768*512/2).
- `W_BEAT`, 18: beat counter width; must hold `FRAME_BEATS`-1.

Ports:
- `HCLK` in 1: the block's only clock.
- `HRESET` in 1: asynchronous, active-high reset.
- `clr` in 1: synchronous soft clear.
- `in_valid` in 1: input beat valid; there is no ready, so the source cannot be stalled.
- `in_r0`, `in_g0`, `in_b0`, `in_r1`, `in_g1`, `in_b1` in 8 each: pixel 0 and pixel 1 channels.
- `out_valid` out 1: FIFO non-empty.
- `out_data` out 32: FIFO head word.
- `out_ready` in 1: consumer accepts `out_data`.
- `fifo_level` out `W_FIFO`+1: current number of occupied FIFO entries.
- `overflow` out 1: sticky; set when any beat or flush word is dropped.
- `frame_done` out 1: one-cycle pulse at end of frame.

## Operation
- Byte stream order per beat: r0, g0, b0, r1, g1, b1. Word byte k occupies bits [8k+7:8k]; the first stream byte goes in [7:0].
- The packer has a phase bit and a 16-bit hold register.
  - Phase 0 beat: push {r1,b0,g0,r0}. Hold becomes {b1,g1}. Phase goes to 1. Needs 1 free entry.
  - Phase 1 beat: push {g0,r0,hold} then {b1,g1,r1,b0}, in that order. Phase goes to 0. Needs 2 free entries.
- Free space is computed as `FIFO_DEPTH` minus `fifo_level` at the start of the cycle. A pop in the same cycle does not add space.
- If free space is insufficient, the whole beat is dropped:
  - nothing is pushed;
  - phase and hold are unchanged;
  - `overflow` is set.
- Beat counter: increments on every `in_valid` beat, accepted or dropped.
- On the beat where the counter equals `FRAME_BEATS`-1:
  - the counter goes to 0;
  - `frame_done` pulses in the next cycle.
- Flush: if phase is 1 after the final beat of a frame, the cycle after that beat is a FLUSH cycle.
  - FLUSH pushes {16'h0, hold} and sets phase to 0.
  - If the FIFO is full, the flush word is dropped, `overflow` is set, and phase still goes to 0.
  - Any `in_valid` during a FLUSH cycle is dropped, sets `overflow`, and is counted.
- Pop: when `out_valid` and `out_ready` are both high, the head advances. Push and pop in the same cycle update the level by (pushes - 1).
- `clr`, and `HRESET` at any time including mid-frame, return the block to reset values:
  - FIFO empty, phase 0, hold 0, counter 0, no pending flush;
  - `overflow` 0, `frame_done` 0.
  - `clr` takes priority over all same-cycle events.
- Reset values of outputs: `out_valid`=0, `out_data`=0 while empty, `fifo_level`=0, `overflow`=0, `frame_done`=0.

## Timing
- Latency: a beat accepted in cycle n makes its word(s) visible from cycle n+1 (`out_valid`=1, `fifo_level` updated).
- `out_data` comes combinationally from the head entry and is stable while `out_valid`=1 and `out_ready`=0.
- `overflow` rises the cycle after the drop.
- `frame_done` is high exactly one cycle, at n+1 after the final beat. When a FLUSH cycle occurs, it coincides with the `frame_done` cycle.
- Pointers wrap modulo `FIFO_DEPTH`. The level ranges 0..`FIFO_DEPTH`; full means the level equals `FIFO_DEPTH`.

## Test plan
- Reset: assert `HRESET` -> `out_valid`=0, `fifo_level`=0, `overflow`=0, `frame_done`=0.
- Packing: `out_ready`=0; send beats 01..06 then 07..0C.
  - Required FIFO contents: 0x04030201, 0x08070605, 0x0C0B0A09.
  - `fifo_level`=3.
  - Then `out_ready`=1 pops them in that order.
- Overflow: `out_ready`=0; send 11 beats.
  - After the 11th beat, `fifo_level`=16 with `overflow`=0.
  - A 12th beat is dropped: `fifo_level` stays 16 and `overflow`=1.
  - After draining, the next beat packs as phase 1.
- Frame flush: `FRAME_BEATS`=3; beats 01..06, 07..0C, 0D..12.
  - Required words: 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D, 0x00001211.
  - `frame_done` pulses once.
- Simultaneous push/pop: level 2, `out_ready`=1, and a phase-1 beat in the same cycle -> `fifo_level`=3 next cycle, word order preserved.
- Mid-frame abort: `clr` pulse, then separately `HRESET`, with `out_valid`=1 and phase 1.
  - Required: `fifo_level`=0, `overflow`=0.
  - The next beat packs as phase 0 and the beat counter restarts at 0.

Source files
------------

// File: rtl/lcd_pix_packer.sv
// lcd_pix_packer: packs two-pixel RGB beats into little-endian 32-bit
// words, buffers them in a FWFT FIFO, tracks frames and flushes tails.
module lcd_pix_packer #(
  parameter int IMG_PIX_W   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int W_FIFO      = 4,
  parameter int FRAME_BEATS = 196608,
  parameter int W_BEAT      = 18
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic [IMG_PIX_W-1:0] in_r0,
  input  logic [IMG_PIX_W-1:0] in_g0,
  input  logic [IMG_PIX_W-1:0] in_b0,
  input  logic [IMG_PIX_W-1:0] in_r1,
  input  logic [IMG_PIX_W-1:0] in_g1,
  input  logic [IMG_PIX_W-1:0] in_b1,
  output logic                 out_valid,
  output logic [31:0]          out_data,
  input  logic                 out_ready,
  output logic [W_FIFO:0]      fifo_level,
  output logic                 overflow,
  output logic                 frame_done
);

  localparam logic [W_FIFO:0] LP_DEPTH =
    (W_FIFO+1)'(FIFO_DEPTH);
  localparam logic [W_FIFO:0] LP_TWO =
    (W_FIFO+1)'(2);
  localparam logic [W_BEAT-1:0] LP_LAST =
    W_BEAT'(FRAME_BEATS - 1);

  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [W_FIFO-1:0] r_wptr;
  logic [W_FIFO-1:0] r_rptr;
  logic [W_FIFO:0]   r_level;
  logic              r_phase;
  logic [15:0]       r_hold;
  logic [W_BEAT-1:0] r_cnt;
  logic              r_flush;
  logic              r_overflow;
  logic              r_frame_done;

  logic [W_FIFO:0]   w_free;
  logic              w_pop;
  logic              w_last;
  logic [1:0]        w_npush;
  logic [31:0]       w_word0;
  logic [31:0]       w_word1;
  logic              w_phase_nxt;
  logic [15:0]       w_hold_nxt;
  logic              w_drop;
  logic [W_FIFO-1:0] w_wptr1;

  // Space is judged on the start-of-cycle level; a same-cycle pop
  // does not help an incoming beat.
  assign w_free  = LP_DEPTH - r_level;
  assign w_pop   = (r_level != '0) && out_ready;
  assign w_last  = in_valid && (r_cnt == LP_LAST);
  assign w_wptr1 = r_wptr + W_FIFO'(1);

  // Decide what this cycle pushes and whether anything is dropped.
  always_comb begin
    w_npush     = 2'd0;
    w_word0     = '0;
    w_word1     = '0;
    w_phase_nxt = r_phase;
    w_hold_nxt  = r_hold;
    w_drop      = 1'b0;
    if (r_flush) begin
      w_phase_nxt = 1'b0;
      if (w_free != '0) begin
        w_npush = 2'd1;
        w_word0 = {16'h0000, r_hold};
      end else begin
        w_drop = 1'b1;
      end
      if (in_valid) begin
        w_drop = 1'b1;
      end
    end else if (in_valid) begin
      if (!r_phase) begin
        if (w_free != '0) begin
          w_npush     = 2'd1;
          w_word0     = {in_r1, in_b0, in_g0, in_r0};
          w_hold_nxt  = {in_b1, in_g1};
          w_phase_nxt = 1'b1;
        end else begin
          w_drop = 1'b1;
        end
      end else begin
        if (w_free >= LP_TWO) begin
          w_npush     = 2'd2;
          w_word0     = {in_g0, in_r0, r_hold};
          w_word1     = {in_b1, in_g1, in_r1, in_b0};
          w_phase_nxt = 1'b0;
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  // FIFO storage; contents need no reset since level gates visibility.
  always_ff @(posedge HCLK) begin
    if (!clr) begin
      if (w_npush != 2'd0) begin
        r_mem[r_wptr] <= w_word0;
      end
      if (w_npush == 2'd2) begin
        r_mem[w_wptr1] <= w_word1;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      r_wptr  <= r_wptr + W_FIFO'(w_npush);
      if (w_pop) begin
        r_rptr <= r_rptr + W_FIFO'(1);
      end
      r_level <= r_level + (W_FIFO+1)'(w_npush)
                 - (W_FIFO+1)'(w_pop);
    end
  end

  // Packer phase, hold bytes, frame counter and pending flush.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_phase <= 1'b0;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_flush <= 1'b0;
    end else if (clr) begin
      r_phase <= 1'b0;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_flush <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_hold  <= w_hold_nxt;
      if (in_valid) begin
        r_cnt <= w_last ? '0 : r_cnt + W_BEAT'(1);
      end
      r_flush <= w_last && w_phase_nxt;
    end
  end

  // Sticky overflow and one-cycle end-of-frame pulse.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (clr) begin
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_overflow   <= r_overflow | w_drop;
      r_frame_done <= w_last;
    end
  end

  assign out_valid  = (r_level != '0);
  assign out_data   = out_valid ? r_mem[r_rptr] : 32'h0;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_pix_packer.sv
// tb_lcd_pix_packer: directed bench; b_* is a full-size frame
// instance, f_* a 3-beat-frame instance sharing the same stimulus.
module tb_lcd_pix_packer;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_r0 = '0, in_g0 = '0, in_b0 = '0;
  logic [7:0] in_r1 = '0, in_g1 = '0, in_b1 = '0;
  logic       out_ready = 1'b0;

  logic        b_out_valid, f_out_valid;
  logic [31:0] b_out_data, f_out_data;
  logic [4:0]  b_fifo_level, f_fifo_level;
  logic        b_overflow, f_overflow;
  logic        b_frame_done, f_frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_pix_packer u_big (
    .HCLK(HCLK), .HRESET(HRESET), .clr(clr),
    .in_valid(in_valid),
    .in_r0(in_r0), .in_g0(in_g0), .in_b0(in_b0),
    .in_r1(in_r1), .in_g1(in_g1), .in_b1(in_b1),
    .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(out_ready), .fifo_level(b_fifo_level),
    .overflow(b_overflow), .frame_done(b_frame_done)
  );

  lcd_pix_packer #(.FRAME_BEATS(3), .W_BEAT(2)) u_frm (
    .HCLK(HCLK), .HRESET(HRESET), .clr(clr),
    .in_valid(in_valid),
    .in_r0(in_r0), .in_g0(in_g0), .in_b0(in_b0),
    .in_r1(in_r1), .in_g1(in_g1), .in_b1(in_b1),
    .out_valid(f_out_valid), .out_data(f_out_data),
    .out_ready(out_ready), .fifo_level(f_fifo_level),
    .overflow(f_overflow), .frame_done(f_frame_done)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic beat(input logic [7:0] s);
    in_r0 = s;
    in_g0 = s + 8'd1;
    in_b0 = s + 8'd2;
    in_r1 = s + 8'd3;
    in_g1 = s + 8'd4;
    in_b1 = s + 8'd5;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (b_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %0b exp 0", b_out_valid);
    end
    n_tests++;
    if (b_fifo_level !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_level got %0d exp 0", b_fifo_level);
    end
    n_tests++;
    if (b_overflow !== 1'b0 || b_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %0b%0b exp 00",
               b_overflow, b_frame_done);
    end
    n_tests++;
    if (b_out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data got %08h exp 0", b_out_data);
    end
  endtask

  task automatic test_packing();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h04030201;
    exp_w[1] = 32'h08070605;
    exp_w[2] = 32'h0C0B0A09;
    do_clr();
    out_ready = 1'b0;
    beat(8'h01);
    n_tests++;
    if (b_fifo_level !== 5'd1 || b_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pack_latency level %0d valid %0b exp 1 1",
               b_fifo_level, b_out_valid);
    end
    beat(8'h07);
    n_tests++;
    if (b_fifo_level !== 5'd3) begin
      n_fail++;
      $display("FAIL pack_level got %0d exp 3", b_fifo_level);
    end
    cyc();
    n_tests++;
    if (b_out_data !== exp_w[0]) begin
      n_fail++;
      $display("FAIL pack_hold got %08h exp %08h",
               b_out_data, exp_w[0]);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (b_out_data !== exp_w[i]) begin
        n_fail++;
        $display("FAIL pack_word%0d got %08h exp %08h",
                 i, b_out_data, exp_w[i]);
      end
      cyc();
    end
    out_ready = 1'b0;
    n_tests++;
    if (b_fifo_level !== 5'd0 || b_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pack_empty level %0d valid %0b exp 0 0",
               b_fifo_level, b_out_valid);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] e;
    do_clr();
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      beat(8'(i * 6 + 1));
    end
    n_tests++;
    if (b_fifo_level !== 5'd16 || b_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_full level %0d ovf %0b exp 16 0",
               b_fifo_level, b_overflow);
    end
    beat(8'hA0);
    n_tests++;
    if (b_fifo_level !== 5'd16 || b_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drop level %0d ovf %0b exp 16 1",
               b_fifo_level, b_overflow);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      e = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
      n_tests++;
      if (b_out_data !== e) begin
        n_fail++;
        $display("FAIL ovf_word%0d got %08h exp %08h",
                 k, b_out_data, e);
      end
      cyc();
    end
    out_ready = 1'b0;
    n_tests++;
    if (b_fifo_level !== 5'd0 || b_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drained level %0d ovf %0b exp 0 1",
               b_fifo_level, b_overflow);
    end
    beat(8'h50);
    n_tests++;
    if (b_fifo_level !== 5'd2 || b_out_data !== 32'h51504241) begin
      n_fail++;
      $display("FAIL ovf_resume level %0d data %08h exp 2 51504241",
               b_fifo_level, b_out_data);
    end
    out_ready = 1'b1;
    cyc();
    n_tests++;
    if (b_out_data !== 32'h55545352) begin
      n_fail++;
      $display("FAIL ovf_resume2 got %08h exp 55545352", b_out_data);
    end
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_frame_flush();
    logic [31:0] exp_w [5];
    exp_w[0] = 32'h04030201;
    exp_w[1] = 32'h08070605;
    exp_w[2] = 32'h0C0B0A09;
    exp_w[3] = 32'h100F0E0D;
    exp_w[4] = 32'h00001211;
    do_clr();
    out_ready = 1'b0;
    beat(8'h01);
    n_tests++;
    if (f_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL frm_early got %0b exp 0", f_frame_done);
    end
    beat(8'h07);
    beat(8'h0D);
    n_tests++;
    if (f_frame_done !== 1'b1 || f_fifo_level !== 5'd4) begin
      n_fail++;
      $display("FAIL frm_done done %0b level %0d exp 1 4",
               f_frame_done, f_fifo_level);
    end
    cyc();
    n_tests++;
    if (f_frame_done !== 1'b0 || f_fifo_level !== 5'd5) begin
      n_fail++;
      $display("FAIL frm_flush done %0b level %0d exp 0 5",
               f_frame_done, f_fifo_level);
    end
    n_tests++;
    if (f_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL frm_ovf got %0b exp 0", f_overflow);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (f_out_data !== exp_w[i]) begin
        n_fail++;
        $display("FAIL frm_word%0d got %08h exp %08h",
                 i, f_out_data, exp_w[i]);
      end
      cyc();
    end
    out_ready = 1'b0;
    n_tests++;
    if (f_fifo_level !== 5'd0 || f_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL frm_end level %0d done %0b exp 0 0",
               f_fifo_level, f_frame_done);
    end
  endtask

  task automatic test_flush_drop();
    do_clr();
    out_ready = 1'b0;
    beat(8'h01);
    beat(8'h07);
    beat(8'h0D);
    beat(8'h20);
    n_tests++;
    if (f_overflow !== 1'b1 || f_fifo_level !== 5'd5) begin
      n_fail++;
      $display("FAIL fdrop_ovf ovf %0b level %0d exp 1 5",
               f_overflow, f_fifo_level);
    end
    beat(8'h30);
    n_tests++;
    if (f_frame_done !== 1'b0 || f_fifo_level !== 5'd6) begin
      n_fail++;
      $display("FAIL fdrop_mid done %0b level %0d exp 0 6",
               f_frame_done, f_fifo_level);
    end
    beat(8'h40);
    n_tests++;
    if (f_frame_done !== 1'b1 || f_fifo_level !== 5'd8) begin
      n_fail++;
      $display("FAIL fdrop_end done %0b level %0d exp 1 8",
               f_frame_done, f_fifo_level);
    end
    cyc();
    n_tests++;
    if (f_fifo_level !== 5'd8) begin
      n_fail++;
      $display("FAIL fdrop_noflush level %0d exp 8", f_fifo_level);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h100F0E0D;
    exp_w[1] = 32'h14131211;
    exp_w[2] = 32'h18171615;
    do_clr();
    out_ready = 1'b0;
    beat(8'h01);
    beat(8'h07);
    beat(8'h0D);
    out_ready = 1'b1;
    n_tests++;
    if (b_out_data !== 32'h04030201) begin
      n_fail++;
      $display("FAIL b2b_pre0 got %08h exp 04030201", b_out_data);
    end
    cyc();
    n_tests++;
    if (b_out_data !== 32'h08070605) begin
      n_fail++;
      $display("FAIL b2b_pre1 got %08h exp 08070605", b_out_data);
    end
    cyc();
    n_tests++;
    if (b_fifo_level !== 5'd2) begin
      n_fail++;
      $display("FAIL b2b_lvl2 got %0d exp 2", b_fifo_level);
    end
    beat(8'h13);
    n_tests++;
    if (b_fifo_level !== 5'd3) begin
      n_fail++;
      $display("FAIL b2b_level got %0d exp 3", b_fifo_level);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (b_out_data !== exp_w[i]) begin
        n_fail++;
        $display("FAIL b2b_word%0d got %08h exp %08h",
                 i, b_out_data, exp_w[i]);
      end
      cyc();
    end
    out_ready = 1'b0;
    n_tests++;
    if (b_fifo_level !== 5'd0) begin
      n_fail++;
      $display("FAIL b2b_empty got %0d exp 0", b_fifo_level);
    end
  endtask

  task automatic test_abort();
    do_clr();
    out_ready = 1'b0;
    beat(8'h01);
    beat(8'h07);
    beat(8'h0D);
    beat(8'h20);
    beat(8'h30);
    n_tests++;
    if (f_overflow !== 1'b1 || f_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre ovf %0b valid %0b exp 1 1",
               f_overflow, f_out_valid);
    end
    do_clr();
    n_tests++;
    if (f_fifo_level !== 5'd0 || f_overflow !== 1'b0 ||
        f_out_valid !== 1'b0 || f_out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL clr_state level %0d ovf %0b valid %0b data %08h",
               f_fifo_level, f_overflow, f_out_valid, f_out_data);
    end
    beat(8'h41);
    n_tests++;
    if (f_fifo_level !== 5'd1 || f_out_data !== 32'h44434241) begin
      n_fail++;
      $display("FAIL clr_phase level %0d data %08h exp 1 44434241",
               f_fifo_level, f_out_data);
    end
    beat(8'h47);
    n_tests++;
    if (f_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_cnt_early got %0b exp 0", f_frame_done);
    end
    beat(8'h4D);
    n_tests++;
    if (f_frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_cnt_end got %0b exp 1", f_frame_done);
    end
    beat(8'h60);
    beat(8'h70);
    n_tests++;
    if (f_overflow !== 1'b1 || f_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre ovf %0b valid %0b exp 1 1",
               f_overflow, f_out_valid);
    end
    HRESET = 1'b1;
    #1;
    n_tests++;
    if (f_fifo_level !== 5'd0 || f_overflow !== 1'b0 ||
        f_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_state level %0d ovf %0b valid %0b exp 0 0 0",
               f_fifo_level, f_overflow, f_out_valid);
    end
    cyc();
    HRESET = 1'b0;
    cyc();
    beat(8'h81);
    n_tests++;
    if (f_fifo_level !== 5'd1 || f_out_data !== 32'h84838281) begin
      n_fail++;
      $display("FAIL rst_phase level %0d data %08h exp 1 84838281",
               f_fifo_level, f_out_data);
    end
    beat(8'h87);
    n_tests++;
    if (f_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cnt_early got %0b exp 0", f_frame_done);
    end
    beat(8'h8D);
    n_tests++;
    if (f_frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_cnt_end got %0b exp 1", f_frame_done);
    end
  endtask

  initial begin
    HRESET = 1'b1;
    cyc();
    cyc();
    test_reset();
    HRESET = 1'b0;
    cyc();
    test_packing();
    test_overflow();
    test_frame_flush();
    test_flush_drop();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
